seg_scan_driver: RTL and testbench

Time-multiplexed 7-segment scan driver for the clock/alarm display. It takes NUM_DIGITS 4-bit BCH digit codes and drives one shared segment bus plus one-hot digit enables, one digit per scan slot. Each slot starts with a blanking interval to prevent ghosting. Its segment encoding is the exact inverse of the seg-to-BCH decoder downstream, so seg_out can be looped back and decoded for self-check.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/bch_to_seg.sv | 30 +++
 rtl/seg_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver and the downstream seg-to-BCH decoder:
// digit codes, segment patterns {a,b,c,d,e,f,g} and the scan FSM state type.
package seg_pkg;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;
  localparam logic [3:0] CODE_A     = 4'd12;
  localparam logic [3:0] CODE_P     = 4'd13;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_P    = 7'b1100111;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/bch_to_seg.sv
// Combinational BCH digit code to 7-segment pattern encoder; codes 11, 14 and 15 are dark.
module bch_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // code lookup
  always_comb begin
    case (i_code)
      4'd0:       o_seg = SEG_0;
      4'd1:       o_seg = SEG_1;
      4'd2:       o_seg = SEG_2;
      4'd3:       o_seg = SEG_3;
      4'd4:       o_seg = SEG_4;
      4'd5:       o_seg = SEG_5;
      4'd6:       o_seg = SEG_6;
      4'd7:       o_seg = SEG_7;
      4'd8:       o_seg = SEG_8;
      4'd9:       o_seg = SEG_9;
      CODE_DASH:  o_seg = SEG_DASH;
      CODE_BLANK: o_seg = SEG_OFF;
      CODE_A:     o_seg = SEG_A;
      CODE_P:     o_seg = SEG_P;
      default:    o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-slot anti-ghosting blanking and a per-frame snapshot.
// Optional digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 1000
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV  = 12500000
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam scan_state_e      SLOT_START = (BLANK_CYC == 0) ? DRIVE : BLANK;

  scan_state_e             r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_buf;
  logic [NUM_DIGITS-1:0]   r_dpbuf;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame_done;

  scan_state_e             w_state_n;
  logic [CNT_W-1:0]        w_cnt_n;
  logic [IDX_W-1:0]        w_idx_n;
  logic                    w_snap;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_buf_n;
  logic [NUM_DIGITS-1:0]   w_dpbuf_n;
  logic [3:0]              w_code;
  logic [6:0]              w_seg;
  logic                    w_mask;

  // next scan position; any encoding other than BLANK/DRIVE restarts like IDLE
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_snap    = 1'b0;
    w_wrap    = 1'b0;
    if (!enable) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
      w_idx_n   = '0;
    end else if (r_state != BLANK && r_state != DRIVE) begin
      w_state_n = SLOT_START;
      w_cnt_n   = '0;
      w_idx_n   = '0;
      w_snap    = 1'b1;
    end else if (r_cnt == CNT_LAST) begin
      w_state_n = SLOT_START;
      w_cnt_n   = '0;
      if (r_idx == IDX_LAST) begin
        w_idx_n = '0;
        w_snap  = 1'b1;
        w_wrap  = 1'b1;
      end else begin
        w_idx_n = r_idx + IDX_W'(1);
      end
    end else begin
      w_cnt_n = r_cnt + CNT_W'(1);
      if (r_cnt == BLANK_LAST) begin
        w_state_n = DRIVE;
      end else begin
        w_state_n = r_state;
      end
    end
  end

  // Outputs are registered from the next position, so the encoder sees the post-snapshot buffer.
  assign w_buf_n   = w_snap ? digits_in : r_buf;
  assign w_dpbuf_n = w_snap ? dp_in : r_dpbuf;
  assign w_code    = w_buf_n[{w_idx_n, 2'b00} +: 4];

  bch_to_seg u_enc (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

`ifdef SEG_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_off;
  logic             w_blink_wrap;
  logic             w_blink_off_n;

  assign w_blink_wrap  = (r_blink_cnt == BLK_W'(BLINK_DIV - 1));
  assign w_blink_off_n = r_blink_off ^ w_blink_wrap;
  assign w_mask        = w_blink_off_n & blink_mask[w_idx_n];

  // free-running blink phase, independent of the scan FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLK_W'(1);
      r_blink_off <= w_blink_off_n;
    end
  end
`else
  assign w_mask = 1'b0;
`endif

  // scan FSM, frame buffer and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_buf        <= '0;
      r_dpbuf      <= '0;
      r_seg        <= 7'd0;
      r_dp         <= 1'b0;
      r_sel        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_idx        <= w_idx_n;
      r_buf        <= w_buf_n;
      r_dpbuf      <= w_dpbuf_n;
      r_frame_done <= w_wrap;
      if (w_state_n == DRIVE) begin
        r_sel <= NUM_DIGITS'(1) << w_idx_n;
        r_seg <= w_mask ? 7'd0 : w_seg;
        r_dp  <= w_mask ? 1'b0 : w_dpbuf_n[w_idx_n];
      end else begin
        r_sel <= '0;
        r_seg <= 7'd0;
        r_dp  <= 1'b0;
      end
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign digit_sel  = r_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (6 digits, 8-clock slots, 2 blank clocks) plus a BLANK_CYC=0 instance.
// Blink checks are compiled when SEG_BLINK_EN is defined.
module tb_seg_scan_driver;

  localparam int ND = 6;

  typedef struct packed {
    logic [5:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [3:0] code;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          en0;
  logic [23:0]   digits_in;
  logic [5:0]    dp_in;
  logic [6:0]    seg_out, seg0;
  logic          dp_out, dp0;
  logic [5:0]    digit_sel, sel0;
  logic          frame_done, fd0;
`ifdef SEG_BLINK_EN
  logic [5:0]    blink_mask;
`endif

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ec;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (8),
    .BLANK_CYC  (2)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_DIV  (16)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (8),
    .BLANK_CYC  (0)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_DIV  (16)
`endif
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en0),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
`ifdef SEG_BLINK_EN
    .blink_mask (6'b000000),
`endif
    .seg_out    (seg0),
    .dp_out     (dp0),
    .digit_sel  (sel0),
    .frame_done (fd0)
  );

  always #5 clk = ~clk;

  // posedges since the last reset release; the blink phase is a pure function of it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  function automatic logic [6:0] spec_seg(input logic [3:0] c);
    case (c)
      4'd0:    spec_seg = 7'b1111110;
      4'd1:    spec_seg = 7'b0110000;
      4'd2:    spec_seg = 7'b1101101;
      4'd3:    spec_seg = 7'b1111001;
      4'd4:    spec_seg = 7'b0110011;
      4'd5:    spec_seg = 7'b1011011;
      4'd6:    spec_seg = 7'b1011111;
      4'd7:    spec_seg = 7'b1110000;
      4'd8:    spec_seg = 7'b1111111;
      4'd9:    spec_seg = 7'b1111011;
      4'd10:   spec_seg = 7'b0000001;
      4'd12:   spec_seg = 7'b1110111;
      4'd13:   spec_seg = 7'b1100111;
      default: spec_seg = 7'b0000000;
    endcase
  endfunction

  // downstream seg-to-BCH decoder used for loopback
  function automatic logic [3:0] spec_dec(input logic [6:0] s);
    for (int c = 0; c < 14; c++) begin
      if (spec_seg(4'(c)) === s) return 4'(c);
    end
    return 4'hF;
  endfunction

  task automatic push_dark(input int n);
    exp_t e;
    e = '0;
    for (int k = 0; k < n; k++) q.push_back(e);
  endtask

  // first n cycles of a frame after a snapshot: 2 dark then 6 driven cycles per slot
  task automatic push_frame(input logic [23:0] d, input logic [5:0] dpv, input bit first, input int n);
    exp_t e;
    int   slot;
    for (int k = 0; k < n; k++) begin
      slot = k / 8;
      e    = '0;
      e.fd = (k == 0) && !first;
      if ((k % 8) >= 2) begin
        e.sel  = 6'b000001 << slot;
        e.code = d[slot*4 +: 4];
        e.seg  = spec_seg(e.code);
        e.dp   = dpv[slot];
      end
      q.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int n);
    exp_t       e;
    logic [3:0] dec_exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty", tag);
      end else begin
        e = q.pop_front();
        assert ({digit_sel, seg_out, dp_out, frame_done} === {e.sel, e.seg, e.dp, e.fd})
        else begin
          errors++;
          $error("FAIL %s: got sel=%b seg=%b dp=%b fd=%b exp sel=%b seg=%b dp=%b fd=%b",
                 tag, digit_sel, seg_out, dp_out, frame_done, e.sel, e.seg, e.dp, e.fd);
        end
        if (e.sel != 6'd0) begin
          dec_exp = (e.code >= 4'd14) ? 4'd11 : e.code;
          checks++;
          assert (spec_dec(seg_out) === dec_exp)
          else begin
            errors++;
            $error("FAIL %s_loopback: got %0d exp %0d", tag, spec_dec(seg_out), dec_exp);
          end
        end
      end
    end
  endtask

  task automatic check_dark(input string tag);
    checks++;
    assert ({digit_sel, seg_out, dp_out, frame_done, sel0, seg0, dp0, fd0} === 32'd0)
    else begin
      errors++;
      $error("FAIL %s: got sel=%b seg=%b dp=%b fd=%b sel0=%b seg0=%b exp all zero",
             tag, digit_sel, seg_out, dp_out, frame_done, sel0, seg0);
    end
  endtask

  initial begin
    logic [23:0] d1, d2, d3a, d3b, d4, d5, d6, dd;
    logic [5:0]  esel;
    logic [6:0]  eseg;
    logic        edp, efd, off;
    int          slot, cnt;

    clk = 1'b0; rst_n = 1'b0; enable = 1'b0; en0 = 1'b0;
    digits_in = 24'd0; dp_in = 6'd0;
`ifdef SEG_BLINK_EN
    blink_mask = 6'd0;
`endif
    repeat (2) @(negedge clk);
    check_dark("reset");
    rst_n = 1'b1;
    push_dark(3);
    drain("idle", 3);

    // basic scan, two full frames
    d1 = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    digits_in = d1; dp_in = 6'b000010; enable = 1'b1;
    push_frame(d1, 6'b000010, 1'b1, 48);
    push_frame(d1, 6'b000010, 1'b0, 48);
    drain("scan", 96);

    // loopback sweep over every code
    d2 = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    digits_in = d2; dp_in = 6'b100001;
    push_frame(d2, 6'b100001, 1'b0, 48);
    drain("codes_a", 48);
    d2 = {4'd12, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6};
    digits_in = d2; dp_in = 6'b000000;
    push_frame(d2, 6'b000000, 1'b0, 48);
    drain("codes_b", 48);
    d2 = {4'd1, 4'd0, 4'd15, 4'd14, 4'd11, 4'd13};
    digits_in = d2; dp_in = 6'b111111;
    push_frame(d2, 6'b111111, 1'b0, 48);
    drain("codes_c", 48);

    // inputs change during slot 3; the running frame keeps its snapshot
    d3a = {4'd9, 4'd8, 4'd7, 4'd3, 4'd2, 4'd1};
    digits_in = d3a; dp_in = 6'b101000;
    push_frame(d3a, 6'b101000, 1'b0, 48);
    drain("snap_old", 28);
    d3b = {4'd12, 4'd13, 4'd10, 4'd4, 4'd4, 4'd4};
    digits_in = d3b; dp_in = 6'b010101;
    push_frame(d3b, 6'b010101, 1'b0, 48);
    drain("snap_old", 20);
    drain("snap_new", 48);

    // enable drop in the drive phase of slot 2, then restart with fresh data
    push_frame(d3b, 6'b010101, 1'b0, 20);
    drain("pre_drop", 20);
    enable = 1'b0;
    d4 = {4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    digits_in = d4; dp_in = 6'b000001;
    push_dark(4);
    drain("drop", 4);
    enable = 1'b1;
    push_frame(d4, 6'b000001, 1'b1, 48);
    drain("reenable", 48);

    // asynchronous reset while digit 0 is driven
    push_frame(d4, 6'b000001, 1'b0, 4);
    drain("pre_rst", 4);
    #2 rst_n = 1'b0;
    #1 check_dark("async_rst");
    push_dark(2);
    drain("in_rst", 2);
    rst_n = 1'b1;
    push_frame(d4, 6'b000001, 1'b1, 48);
    drain("post_rst", 48);

    // BLANK_CYC=0 instance: no dark cycle while enabled, boundary snapshot still applies
    enable = 1'b0;
    d5 = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    d6 = {4'd7, 4'd8, 4'd9, 4'd0, 4'd10, 4'd12};
    digits_in = d5; dp_in = 6'b001100; en0 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      slot = (k / 8) % 6;
      dd   = (k < 48) ? d5 : d6;
      esel = 6'b000001 << slot;
      eseg = spec_seg(dd[slot*4 +: 4]);
      edp  = dp_in[slot];
      efd  = (k == 48) || (k == 96);
      checks++;
      assert ({sel0, seg0, dp0, fd0} === {esel, eseg, edp, efd})
      else begin
        errors++;
        $error("FAIL noblank k=%0d: got sel=%b seg=%b dp=%b fd=%b exp sel=%b seg=%b dp=%b fd=%b",
               k, sel0, seg0, dp0, fd0, esel, eseg, edp, efd);
      end
      if (k == 20) digits_in = d6;
    end
    en0 = 1'b0;

`ifdef SEG_BLINK_EN
    // digit 2 blinks with a 16-clock half period; scan timing is unchanged
    digits_in = d1; dp_in = 6'b000100; blink_mask = 6'b000100;
    enable = 1'b1;
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      slot = (k / 8) % 6;
      cnt  = k % 8;
      off  = ((ec / 16) % 2) == 1;
      esel = 6'd0; eseg = 7'd0; edp = 1'b0;
      efd  = (k > 0) && (k % 48 == 0);
      if (cnt >= 2) begin
        esel = 6'b000001 << slot;
        if (!(slot == 2 && off)) begin
          eseg = spec_seg(d1[slot*4 +: 4]);
          edp  = dp_in[slot];
        end
      end
      checks++;
      assert ({digit_sel, seg_out, dp_out, frame_done} === {esel, eseg, edp, efd})
      else begin
        errors++;
        $error("FAIL blink k=%0d: got sel=%b seg=%b dp=%b fd=%b exp sel=%b seg=%b dp=%b fd=%b",
               k, digit_sel, seg_out, dp_out, frame_done, esel, eseg, edp, efd);
      end
    end
    enable = 1'b0;
`endif

    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_left: got %0d entries exp 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
